// File: rtl/spmi_pkg.sv
// rtl/spmi_pkg.sv - shared widths, capture-word field offsets and channel state type
package spmi_pkg;

    localparam int PKT_W   = 13;
    localparam int TS_W    = 16;

    localparam int PKT_LSB = 0;
    localparam int TS_LSB  = PKT_W;
    localparam int PAR_BIT = TS_LSB + TS_W;
    localparam int OVF_BIT = PAR_BIT + 1;
    localparam int CH_LSB  = OVF_BIT + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_CLR = 2'd2
    } ch_state_e;

endpackage

// File: rtl/spmi_cap_fifo.sv
// rtl/spmi_cap_fifo.sv - count-based first-word-fall-through capture FIFO
module spmi_cap_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    // Full is judged on the registered count, so a pop never frees a slot for a same-cycle push.
    assign in_tready  = (count != (AW+1)'(DEPTH));
    assign out_tvalid = (count != '0);
    assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;
    assign push       = in_tvalid & in_tready;
    assign pop        = out_tvalid & out_tready;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= in_tdata;
    end

endmodule

// File: rtl/spmi_capture_arbiter.sv
// rtl/spmi_capture_arbiter.sv - round-robin capture of SPMI receiver frames into a timestamped word stream
module spmi_capture_arbiter #(
    parameter int  NCH   = 2,
    parameter int  PKT_W = spmi_pkg::PKT_W,
    parameter int  TS_W  = spmi_pkg::TS_W,
    parameter int  DEPTH = 4,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int OUT_W = CHW + 2 + TS_W + PKT_W
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic [NCH*PKT_W-1:0] pkt_in,
    input  logic [NCH-1:0]     pkt_valid,
    input  logic [NCH-1:0]     pkt_overflow,
    output logic [NCH-1:0]     pkt_fetched,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clear_ovf,
    output logic [NCH-1:0]     ovf_seen
);
    import spmi_pkg::*;

    ch_state_e        st     [NCH];
    ch_state_e        st_nxt [NCH];
    logic [TS_W-1:0]  ts_q   [NCH];
    logic [TS_W-1:0]  ts_cnt;
    logic [CHW-1:0]   last_grant;
    logic [CHW-1:0]   gnt_ch;
    logic [CHW-1:0]   cand;
    logic             gnt_vld;
    logic             fifo_ready;
    logic [PKT_W-1:0] gnt_pkt;
    logic [OUT_W-1:0] push_word;

    // Search starts just after the last winner so every pending channel gets a turn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = CHW'((int'(last_grant) + i) % NCH);
            if (!gnt_vld && fifo_ready && st[cand] == PEND) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    // The receiver holds its frame until fetched, so it is read straight off the port.
    assign gnt_pkt   = pkt_in[int'(gnt_ch)*PKT_W +: PKT_W];
    assign push_word = {gnt_ch, pkt_overflow[gnt_ch], ^gnt_pkt, ts_q[gnt_ch], gnt_pkt};

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            st_nxt[k] = st[k];
            case (st[k])
                IDLE:     if (pkt_valid[k]) st_nxt[k] = PEND;
                PEND:     if (gnt_vld && gnt_ch == CHW'(k)) st_nxt[k] = WAIT_CLR;
                WAIT_CLR: if (!pkt_valid[k]) st_nxt[k] = IDLE;
                default:  st_nxt[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                st[k]   <= IDLE;
                ts_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                st[k] <= st_nxt[k];
                if (st[k] == IDLE && pkt_valid[k]) ts_q[k] <= ts_cnt;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_fetched <= '0;
            last_grant  <= CHW'(NCH - 1);
            ts_cnt      <= '0;
            ovf_seen    <= '0;
        end else begin
            pkt_fetched <= '0;
            if (gnt_vld) begin
                pkt_fetched[gnt_ch] <= 1'b1;
                last_grant          <= gnt_ch;
            end
            ts_cnt   <= ts_cnt + 1'b1;
            ovf_seen <= pkt_overflow | (ovf_seen & ~{NCH{clear_ovf}});
        end
    end

    spmi_cap_fifo #(
        .WIDTH(OUT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .in_tdata   (push_word),
        .in_tvalid  (gnt_vld),
        .in_tready  (fifo_ready),
        .out_tdata  (out_data),
        .out_tvalid (out_valid),
        .out_tready (out_ready)
    );

endmodule

// File: tb/tb_spmi_capture_arbiter.sv
// tb/tb_spmi_capture_arbiter.sv - self-checking bench for spmi_capture_arbiter
module tb_spmi_capture_arbiter;
    import spmi_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int CHW   = 1;
    localparam int OUT_W = CHW + 2 + TS_W + PKT_W;

    logic                 sysclk;
    logic                 reset_n;
    logic [NCH*PKT_W-1:0] pkt_in;
    logic [NCH-1:0]       pkt_valid;
    logic [NCH-1:0]       pkt_overflow;
    logic [NCH-1:0]       pkt_fetched;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 clear_ovf;
    logic [NCH-1:0]       ovf_seen;

    spmi_capture_arbiter #(.NCH(NCH), .PKT_W(PKT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .pkt_in       (pkt_in),
        .pkt_valid    (pkt_valid),
        .pkt_overflow (pkt_overflow),
        .pkt_fetched  (pkt_fetched),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .clear_ovf    (clear_ovf),
        .ovf_seen     (ovf_seen)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Cycles since reset release: the value the timestamp counter must show at the next edge.
    logic [TS_W-1:0] tcnt;
    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) tcnt <= '0;
        else          tcnt <= tcnt + 1'b1;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending/captured bookkeeping per channel plus a queue of expected words.
    logic [NCH-1:0]   m_pend, m_hold, m_fetch, m_ovf;
    logic [TS_W-1:0]  m_ts [NCH];
    int               m_last;
    logic [OUT_W-1:0] m_q [$];

    task automatic model_reset();
        m_pend = '0; m_hold = '0; m_fetch = '0; m_ovf = '0;
        m_last = NCH - 1;
        m_q.delete();
    endtask

    task automatic model_step();
        int g;
        logic [PKT_W-1:0] fr;
        g = -1;
        if (m_q.size() < DEPTH)
            for (int i = 1; i <= NCH; i++)
                if (g < 0 && m_pend[(m_last + i) % NCH]) g = (m_last + i) % NCH;
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        m_fetch = '0;
        if (g >= 0) begin
            fr = pkt_in[g*PKT_W +: PKT_W];
            m_q.push_back({CHW'(g), pkt_overflow[g], ^fr, m_ts[g], fr});
            m_fetch[g] = 1'b1;
            m_last = g;
        end
        for (int k = 0; k < NCH; k++) begin
            if (g == k) begin
                m_pend[k] = 1'b0;
                m_hold[k] = 1'b1;
            end else if (m_hold[k]) begin
                if (!pkt_valid[k]) m_hold[k] = 1'b0;
            end else if (!m_pend[k] && pkt_valid[k]) begin
                m_pend[k] = 1'b1;
                m_ts[k]   = tcnt;
            end
        end
        m_ovf = pkt_overflow | (m_ovf & ~{NCH{clear_ovf}});
    endtask

    task automatic cyc();
        model_step();
        @(posedge sysclk);
        #1;
        chk("model_fetched", 64'(pkt_fetched), 64'(m_fetch));
        chk("model_out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("model_out_data", 64'(out_data), 64'(m_q[0]));
        chk("model_ovf_seen", 64'(ovf_seen), 64'(m_ovf));
    endtask

    task automatic do_reset();
        pkt_in = '0; pkt_valid = '0; pkt_overflow = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int              ch;
        logic [PKT_W-1:0] frame;
        logic            ovf;
        logic [31:0]     exp;
    } vec_t;
    vec_t tv [6];

    logic [TS_W-1:0]  t0;
    logic [PKT_W-1:0] fr5 [5];
    int cur [NCH];
    int fcnt;
    int hold_left [NCH];
    logic [NCH-1:0] rx_seen;

    initial begin
        tv[0] = '{0, 13'h02F5, 1'b0, 32'h200002F5};
        tv[1] = '{1, 13'h1A05, 1'b1, 32'hE0001A05};
        tv[2] = '{0, 13'h02F4, 1'b0, 32'h000002F4};
        tv[3] = '{1, 13'h0000, 1'b0, 32'h80000000};
        tv[4] = '{0, 13'h1FFF, 1'b1, 32'h60001FFF};
        tv[5] = '{1, 13'h0001, 1'b0, 32'hA0000001};
        fr5 = '{13'h0101, 13'h0202, 13'h0303, 13'h0404, 13'h0505};

        pkt_in = '0; pkt_valid = '0; pkt_overflow = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_fetched", 64'(pkt_fetched), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_ovf_seen", 64'(ovf_seen), 64'h0);
        reset_n = 1'b1;
        model_reset();

        // Both channels valid at the first edge after reset
        pkt_in = {13'h1A05, 13'h02F5};
        pkt_valid = 2'b11;
        cyc(); chk("both_e0", 64'(pkt_fetched), 64'h0);
        cyc(); chk("both_e1", 64'(pkt_fetched), 64'h1);
        cyc(); chk("both_e2", 64'(pkt_fetched), 64'h2);
        pkt_valid = 2'b00;
        out_ready = 1'b1;
        chk("both_word0", 64'(out_data), 64'h200002F5);
        cyc(); chk("both_word1", 64'(out_data), 64'hA0001A05);
        cyc(); chk("both_empty", 64'(out_valid), 64'h0);

        // Single-channel table
        do_reset();
        for (int v = 0; v < 6; v++) begin
            pkt_in[tv[v].ch*PKT_W +: PKT_W] = tv[v].frame;
            pkt_valid[tv[v].ch]    = 1'b1;
            pkt_overflow[tv[v].ch] = tv[v].ovf;
            out_ready = 1'b1;
            t0 = tcnt;
            cyc(); chk($sformatf("tv%0d_e0_fetch", v), 64'(pkt_fetched), 64'h0);
            cyc();
            chk($sformatf("tv%0d_e1_fetch", v), 64'(pkt_fetched), 64'(1 << tv[v].ch));
            chk($sformatf("tv%0d_valid", v), 64'(out_valid), 64'h1);
            chk($sformatf("tv%0d_word", v), 64'(out_data), 64'(tv[v].exp | (32'(t0) << TS_LSB)));
            chk($sformatf("tv%0d_ovf", v), 64'(ovf_seen), 64'(tv[v].ovf ? (1 << tv[v].ch) : 0));
            pkt_valid = '0; pkt_overflow = '0;
            cyc();
            chk($sformatf("tv%0d_e2_fetch", v), 64'(pkt_fetched), 64'h0);
            chk($sformatf("tv%0d_drained", v), 64'(out_valid), 64'h0);
            chk($sformatf("tv%0d_ovf_sticky", v), 64'(ovf_seen), 64'(tv[v].ovf ? (1 << tv[v].ch) : 0));
            clear_ovf = 1'b1;
            cyc(); chk($sformatf("tv%0d_ovf_clr", v), 64'(ovf_seen), 64'h0);
            clear_ovf = 1'b0;
        end

        // Valid held long after fetch: exactly one capture until it drops
        do_reset();
        pkt_in[PKT_W-1:0] = 13'h0123;
        pkt_valid = 2'b01; out_ready = 1'b1; fcnt = 0;
        for (int c = 0; c < 12; c++) begin cyc(); fcnt += int'(pkt_fetched[0]); end
        chk("hold_one_fetch", 64'(fcnt), 64'd1);
        pkt_valid = 2'b00;
        cyc();
        pkt_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin cyc(); fcnt += int'(pkt_fetched[0]); end
        chk("hold_second_fetch", 64'(fcnt), 64'd2);
        pkt_valid = 2'b00;
        cyc();

        // Backpressure: five frames alternating channels into a four-deep FIFO
        do_reset();
        cur[0] = 0; cur[1] = 1; fcnt = 0;
        pkt_in = {fr5[1], fr5[0]};
        pkt_valid = 2'b11;
        for (int c = 0; c < 30; c++) begin
            cyc();
            for (int k = 0; k < NCH; k++) begin
                if (pkt_fetched[k]) begin
                    fcnt++;
                    pkt_valid[k] = 1'b0;
                    cur[k] += 2;
                end else if (!pkt_valid[k] && cur[k] < 5) begin
                    pkt_in[k*PKT_W +: PKT_W] = fr5[cur[k]];
                    pkt_valid[k] = 1'b1;
                end
            end
        end
        chk("bp_four_fetched", 64'(fcnt), 64'd4);
        chk("bp_full_valid", 64'(out_valid), 64'h1);
        chk("bp_head", 64'(out_data[PKT_W-1:0]), 64'(fr5[0]));
        out_ready = 1'b1;
        cyc(); chk("bp_no_fetch_on_pop", 64'(pkt_fetched), 64'h0);
        out_ready = 1'b0;
        cyc(); chk("bp_fetch_after_pop", 64'(pkt_fetched), 64'h1);
        pkt_valid = 2'b00;
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("bp_order%0d", i), 64'(out_data[PKT_W-1:0]), 64'(fr5[i]));
            cyc();
        end
        chk("bp_drained", 64'(out_valid), 64'h0);

        // Reset between push and pop, frame still held across reset
        do_reset();
        repeat (5) cyc();
        pkt_in[PKT_W-1:0] = 13'h0A5A;
        pkt_valid = 2'b01;
        cyc(); cyc();
        chk("mr_pushed", 64'(out_valid), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("mr_valid_drop", 64'(out_valid), 64'h0);
        chk("mr_fetch_drop", 64'(pkt_fetched), 64'h0);
        #1;
        reset_n = 1'b1;
        model_reset();
        cyc(); cyc();
        chk("mr_refetch", 64'(pkt_fetched), 64'h1);
        chk("mr_ts_restart", 64'(out_data[TS_LSB +: TS_W]), 64'h0);
        chk("mr_packet", 64'(out_data[PKT_W-1:0]), 64'h0A5A);
        pkt_valid = 2'b00;

        // Randomised receivers against the model, light then heavy backpressure
        do_reset();
        rx_seen = '0;
        for (int c = 0; c < 700; c++) begin
            for (int k = 0; k < NCH; k++) begin
                if (pkt_valid[k]) begin
                    if (rx_seen[k]) begin
                        if (hold_left[k] > 0) hold_left[k]--;
                        else pkt_valid[k] = 1'b0;
                    end
                end else if ($urandom_range(99) < 40) begin
                    pkt_in[k*PKT_W +: PKT_W] = PKT_W'($urandom);
                    pkt_valid[k] = 1'b1;
                    rx_seen[k]   = 1'b0;
                    hold_left[k] = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0;
                end
                pkt_overflow[k] = ($urandom_range(15) == 0);
            end
            clear_ovf = ($urandom_range(7) == 0);
            out_ready = ($urandom_range(99) < ((c < 450) ? 70 : 20));
            cyc();
            for (int k = 0; k < NCH; k++) if (pkt_fetched[k]) rx_seen[k] = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
